// File: rtl/prog_loader_pkg.sv
// Shared constants for the program-ROM loader: FSM encoding,
// frame sync nibble and error codes.
package prog_loader_pkg;

    localparam int NIB_W = 4;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_ADDR = 4'd1;
    localparam logic [3:0] ST_LEN  = 4'd2;
    localparam logic [3:0] ST_DHI  = 4'd3;
    localparam logic [3:0] ST_DLO  = 4'd4;
    localparam logic [3:0] ST_CHI  = 4'd5;
    localparam logic [3:0] ST_CLO  = 4'd6;
    localparam logic [3:0] ST_DONE = 4'd7;
    localparam logic [3:0] ST_ERR  = 4'd8;

    localparam logic [NIB_W-1:0] SYNC_DEF = 4'hA;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    function automatic logic in_frame(input logic [3:0] s);
        return (s != ST_IDLE) && (s != ST_DONE) && (s != ST_ERR);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Host nibble stream: valid/ready handshake into the loader.
interface prog_loader_if;
    import prog_loader_pkg::*;

    logic [NIB_W-1:0] in_nib;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_nib, output in_valid, input in_ready);
    modport slave  (input in_nib, input in_valid, output in_ready);
endinterface

// File: rtl/prog_loader_gap_timer.sv
// Idle-gap counter; expired is high on the last allowed idle cycle.
module prog_loader_gap_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    assign expired = en && (cnt == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Framed nibble-stream loader into the 4K x 8 program ROM; holds the
// CPU in reset while loading and checks an additive 8-bit checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int               ADDR_W      = 12,
    parameter int               DATA_W      = 8,
    parameter logic [NIB_W-1:0] SYNC_NIB    = SYNC_DEF,
    parameter int               TIMEOUT_CYC = 1024
) (
    input  logic              clock,
    input  logic              reset,
    prog_loader_if.slave      host,
    input  logic              err_clr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code
);
    logic [3:0]        state;
    logic [1:0]        ncnt;
    logic [7:0]        sh;
    logic [ADDR_W-1:0] base;
    logic [11:0]       len;
    logic [11:0]       idx;
    logic [3:0]        hi;
    logic [7:0]        sum;
    logic              xfer;
    logic              expired;
    logic [11:0]       field;
    logic [7:0]        byte_v;

    assign xfer   = host.in_valid && host.in_ready;
    assign field  = {sh, host.in_nib};
    assign byte_v = {hi, host.in_nib};

    assign host.in_ready = (state != ST_ERR);
    assign cpu_hold      = (state != ST_IDLE);
    assign busy          = (state != ST_IDLE) && (state != ST_ERR);
    assign done          = (state == ST_DONE);

    prog_loader_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap (
        .clock   (clock),
        .reset   (reset),
        .clr     (xfer),
        .en      (in_frame(state)),
        .expired (expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            ncnt      <= '0;
            sh        <= '0;
            base      <= '0;
            len       <= '0;
            idx       <= '0;
            hi        <= '0;
            sum       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err_code  <= ERR_NONE;
        end else begin
            mem_we <= 1'b0;
            if (state == ST_DONE) begin
                state <= ST_IDLE;
            end else if (state == ST_ERR) begin
                if (err_clr) begin
                    state    <= ST_IDLE;
                    err_code <= ERR_NONE;
                end
            end else if (xfer) begin
                unique case (state)
                    ST_IDLE: begin
                        if (host.in_nib == SYNC_NIB) begin
                            state <= ST_ADDR;
                            ncnt  <= '0;
                            idx   <= '0;
                            sum   <= '0;
                        end
                    end
                    ST_ADDR: begin
                        sh   <= field[7:0];
                        ncnt <= ncnt + 1'b1;
                        if (ncnt == 2'd2) begin
                            base  <= ADDR_W'(field);
                            ncnt  <= '0;
                            state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        sh   <= field[7:0];
                        ncnt <= ncnt + 1'b1;
                        if (ncnt == 2'd2) begin
                            len   <= field;
                            ncnt  <= '0;
                            state <= (field == 12'd0) ? ST_CHI : ST_DHI;
                        end
                    end
                    ST_DHI: begin
                        hi    <= host.in_nib;
                        state <= ST_DLO;
                    end
                    ST_DLO: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= base + ADDR_W'(idx);
                        mem_wdata <= DATA_W'(byte_v);
                        sum       <= sum + byte_v;
                        idx       <= idx + 12'd1;
                        state     <= (idx == len - 12'd1) ? ST_CHI : ST_DHI;
                    end
                    ST_CHI: begin
                        hi    <= host.in_nib;
                        state <= ST_CLO;
                    end
                    ST_CLO: begin
                        if (byte_v == sum) begin
                            state <= ST_DONE;
                        end else begin
                            state    <= ST_ERR;
                            err_code <= ERR_CSUM;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (expired) begin
                // A transfer on the expiry cycle is taken above instead.
                state    <= ST_ERR;
                err_code <= ERR_TIMEOUT;
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: per-cycle vector table plus
// hand sequences for timeout and asynchronous reset.
module tb_prog_loader;
    logic        clock;
    logic        reset;
    logic        err_clr;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;

    int total = 0;
    int bad   = 0;

    prog_loader_if intf();

    prog_loader dut (
        .clock     (clock),
        .reset     (reset),
        .host      (intf),
        .err_clr   (err_clr),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err_code  (err_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  nib;
        logic        valid;
        logic        clr;
        logic        we;
        logic [11:0] addr;
        logic [7:0]  data;
        logic        hold;
        logic        dn;
        logic        rdy;
        logic [1:0]  err;
    } vec_t;

    vec_t vq[$];

    task automatic row(input logic [3:0] n, input logic v, input logic c,
                       input logic we, input logic [11:0] a,
                       input logic [7:0] d, input logic h,
                       input logic dn, input logic rd,
                       input logic [1:0] e);
        vec_t r;
        r.nib = n; r.valid = v; r.clr = c;
        r.we = we; r.addr = a; r.data = d;
        r.hold = h; r.dn = dn; r.rdy = rd; r.err = e;
        vq.push_back(r);
    endtask

    // Nibble accepted with no write, processor held, frame running.
    task automatic nib_row(input logic [3:0] n);
        row(n, 1, 0, 0, 12'h0, 8'h0, 1, 0, 1, 2'b00);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] n, input logic v, input logic c);
        intf.in_nib   = n;
        intf.in_valid = v;
        err_clr       = c;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " ready"}, intf.in_ready, 1);
        chk({nm, " hold"}, cpu_hold, 0);
        chk({nm, " we"}, mem_we, 0);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " done"}, done, 0);
        chk({nm, " err"}, err_code, 0);
    endtask

    initial begin
        reset         = 1'b0;
        err_clr       = 1'b0;
        intf.in_nib   = 4'h0;
        intf.in_valid = 1'b0;

        // Good frame: ADDR=010 LEN=2 data 3C,45, csum 81.
        nib_row(4'hA);
        nib_row(4'h0); nib_row(4'h1); nib_row(4'h0);
        nib_row(4'h0); nib_row(4'h0); nib_row(4'h2);
        nib_row(4'h3);
        row(4'hC, 1, 0, 1, 12'h010, 8'h3C, 1, 0, 1, 2'b00);
        nib_row(4'h4);
        row(4'h5, 1, 0, 1, 12'h011, 8'h45, 1, 0, 1, 2'b00);
        nib_row(4'h8);
        row(4'h1, 1, 0, 0, 12'h0, 8'h0, 1, 1, 1, 2'b00);
        row(4'h0, 0, 0, 0, 12'h0, 8'h0, 0, 0, 1, 2'b00);

        // Same frame, csum 88 -> checksum error, clear wins over valid.
        nib_row(4'hA);
        nib_row(4'h0); nib_row(4'h1); nib_row(4'h0);
        nib_row(4'h0); nib_row(4'h0); nib_row(4'h2);
        nib_row(4'h3);
        row(4'hC, 1, 0, 1, 12'h010, 8'h3C, 1, 0, 1, 2'b00);
        nib_row(4'h4);
        row(4'h5, 1, 0, 1, 12'h011, 8'h45, 1, 0, 1, 2'b00);
        nib_row(4'h8);
        row(4'h8, 1, 0, 0, 12'h0, 8'h0, 1, 0, 0, 2'b01);
        row(4'hA, 1, 0, 0, 12'h0, 8'h0, 1, 0, 0, 2'b01);
        row(4'hA, 1, 1, 0, 12'h0, 8'h0, 0, 0, 1, 2'b00);
        row(4'h0, 0, 0, 0, 12'h0, 8'h0, 0, 0, 1, 2'b00);

        // Address wrap: ADDR=FFF LEN=2 data 11,22 csum 33.
        nib_row(4'hA);
        nib_row(4'hF); nib_row(4'hF); nib_row(4'hF);
        nib_row(4'h0); nib_row(4'h0); nib_row(4'h2);
        nib_row(4'h1);
        row(4'h1, 1, 0, 1, 12'hFFF, 8'h11, 1, 0, 1, 2'b00);
        nib_row(4'h2);
        row(4'h2, 1, 0, 1, 12'h000, 8'h22, 1, 0, 1, 2'b00);
        nib_row(4'h3);
        row(4'h3, 1, 0, 0, 12'h0, 8'h0, 1, 1, 1, 2'b00);
        row(4'h0, 0, 0, 0, 12'h0, 8'h0, 0, 0, 1, 2'b00);

        // LEN=0 with csum 00; mid-frame A is plain address data.
        nib_row(4'hA);
        nib_row(4'h5); nib_row(4'hA); nib_row(4'h5);
        nib_row(4'h0); nib_row(4'h0); nib_row(4'h0);
        nib_row(4'h0);
        row(4'h0, 1, 0, 0, 12'h0, 8'h0, 1, 1, 1, 2'b00);
        row(4'h0, 0, 0, 0, 12'h0, 8'h0, 0, 0, 1, 2'b00);

        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock);
        #1;
        chk_idle("reset");
        chk("reset addr", mem_addr, 0);
        chk("reset data", mem_wdata, 0);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].nib, vq[i].valid, vq[i].clr);
            chk($sformatf("r%0d ready", i), intf.in_ready, vq[i].rdy);
            chk($sformatf("r%0d hold", i), cpu_hold, vq[i].hold);
            chk($sformatf("r%0d busy", i), busy, vq[i].hold & vq[i].rdy);
            chk($sformatf("r%0d we", i), mem_we, vq[i].we);
            chk($sformatf("r%0d done", i), done, vq[i].dn);
            chk($sformatf("r%0d err", i), err_code, vq[i].err);
            if (vq[i].we) begin
                chk($sformatf("r%0d addr", i), mem_addr, vq[i].addr);
                chk($sformatf("r%0d data", i), mem_wdata, vq[i].data);
            end
        end

        // Inter-nibble timeout after A,1,2.
        step(4'hA, 1, 0);
        step(4'h1, 1, 0);
        step(4'h2, 1, 0);
        repeat (1023) step(4'h0, 0, 0);
        chk("to pre ready", intf.in_ready, 1);
        chk("to pre err", err_code, 0);
        step(4'h0, 0, 0);
        chk("to ready", intf.in_ready, 0);
        chk("to hold", cpu_hold, 1);
        chk("to err", err_code, 2);
        step(4'h0, 0, 1);
        chk_idle("to clr");

        // Nibble landing on the expiry cycle is accepted.
        step(4'hA, 1, 0);
        step(4'h1, 1, 0);
        step(4'h2, 1, 0);
        repeat (1023) step(4'h0, 0, 0);
        step(4'h3, 1, 0);
        chk("edge ready", intf.in_ready, 1);
        chk("edge err", err_code, 0);
        chk("edge busy", busy, 1);
        repeat (5) step(4'h0, 1, 0);
        chk("edge done", done, 1);
        step(4'h0, 0, 0);
        chk("edge hold", cpu_hold, 0);

        // Non-sync nibble discarded, sync starts a frame.
        step(4'h7, 1, 0);
        chk("pre7 hold", cpu_hold, 0);
        step(4'hA, 1, 0);
        chk("sync hold", cpu_hold, 1);
        step(4'h0, 1, 0); step(4'h2, 1, 0); step(4'h0, 1, 0);
        step(4'h0, 1, 0); step(4'h0, 1, 0); step(4'h2, 1, 0);
        step(4'h5, 1, 0);
        step(4'h6, 1, 0);
        chk("pre we", mem_we, 1);
        chk("pre addr", mem_addr, 12'h020);
        chk("pre data", mem_wdata, 8'h56);
        step(4'h7, 1, 0);

        // Asynchronous reset while waiting for the lo nibble.
        intf.in_nib   = 4'h8;
        intf.in_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk_idle("async");
        chk("async addr", mem_addr, 0);
        chk("async data", mem_wdata, 0);
        @(posedge clock);
        #1;
        chk("rst hold we", mem_we, 0);
        #2 reset = 1'b1;
        step(4'h8, 1, 0);
        chk_idle("post rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
